// File: rtl/riscv_issue_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_issue_ctrl
//
// In-order dual-issue controller. It sits between decode and two execute
// pipes. One decoded pair is held in a two-slot buffer (slot A oldest).
// Every cycle it decides whether slot A goes to pipe0 and slot B to pipe1.
// The decision uses a per-register RAW scoreboard, the intra-pair dependence
// rule, branch-shadow serialisation and the rule that only pipe0 takes mem ops.
//
// Ports:
//   clk, srst_n            clock, synchronous active-low reset
//   hold                   freezes buffer, scoreboard, issue regs, dual_cnt
//   flush                  kills the buffer and issue valids (wins over hold)
//   in_valid_a/b           decode pair valid (b only meaningful with a)
//   in_ready               pair accepted when in_valid_a && in_ready
//   in_pc_*, in_inst_*     instruction PC / code
//   in_regs_*              {ra[14:10], rb[9:5], rd[4:0]}
//   in_attr_*              {wr_en, is_load, is_mem, is_branch}
//   iss0_* / iss1_*        registered issue outputs to pipe0 / pipe1
//   dual_cnt               wrapping count of dual-issue cycles
// ---------------------------------------------------------------------------
module riscv_issue_ctrl #(
  parameter int unsigned ALU_LAT  = 0,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic        clk,
  input  logic        srst_n,
  input  logic        hold,
  input  logic        flush,
  input  logic        in_valid_a,
  input  logic        in_valid_b,
  output logic        in_ready,
  input  logic [31:0] in_pc_a,
  input  logic [31:0] in_pc_b,
  input  logic [31:0] in_inst_a,
  input  logic [31:0] in_inst_b,
  input  logic [14:0] in_regs_a,
  input  logic [14:0] in_regs_b,
  input  logic [3:0]  in_attr_a,
  input  logic [3:0]  in_attr_b,
  output logic        iss0_valid,
  output logic        iss1_valid,
  output logic [31:0] iss0_pc,
  output logic [31:0] iss1_pc,
  output logic [31:0] iss0_inst,
  output logic [31:0] iss1_inst,
  output logic [14:0] iss0_regs,
  output logic [14:0] iss1_regs,
  output logic [31:0] dual_cnt
);

  // Attribute bit positions inside {wr_en, is_load, is_mem, is_branch}.
  localparam int ATTR_WR   = 3;
  localparam int ATTR_LOAD = 2;
  localparam int ATTR_MEM  = 1;
  localparam int ATTR_BR   = 0;

  localparam logic [1:0] ALU_LAT_C  = 2'(ALU_LAT);
  localparam logic [1:0] LOAD_LAT_C = 2'(LOAD_LAT);

  // ---------------------------------------------------------------------
  // Field helpers
  // ---------------------------------------------------------------------
  function automatic logic [4:0] f_ra(input logic [14:0] regs);
    return regs[14:10];
  endfunction

  function automatic logic [4:0] f_rb(input logic [14:0] regs);
    return regs[9:5];
  endfunction

  function automatic logic [4:0] f_rd(input logic [14:0] regs);
    return regs[4:0];
  endfunction

  // A real architectural write: x0 writes are discarded and never tracked.
  function automatic logic f_writes(input logic [3:0] attr, input logic [14:0] regs);
    return attr[ATTR_WR] && (regs[4:0] != 5'd0);
  endfunction

  // Number of cycles a consumer must wait behind this writer.
  function automatic logic [1:0] f_lat(input logic [3:0] attr);
    return attr[ATTR_LOAD] ? LOAD_LAT_C : ALU_LAT_C;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic        a_valid_r;
  logic        b_valid_r;
  logic [31:0] a_pc_r;
  logic [31:0] b_pc_r;
  logic [31:0] a_inst_r;
  logic [31:0] b_inst_r;
  logic [14:0] a_regs_r;
  logic [14:0] b_regs_r;
  logic [3:0]  a_attr_r;
  logic [3:0]  b_attr_r;
  logic [1:0]  sb_cnt_r [0:31];

  // ---------------------------------------------------------------------
  // Combinational decision signals
  // ---------------------------------------------------------------------
  logic [31:0] busy_s;
  logic        a_iss_s;
  logic        b_iss_s;
  logic        b_raw_s;
  logic        b_ops_free_s;
  logic        slots_clear_s;
  logic        accept_s;
  logic        sb_update_s;
  logic [1:0]  sb_nxt_s [0:31];

  // Slot A's mem flag is never consulted: pipe0 accepts every kind of op.
  logic        unused_a_mem_s;
  assign unused_a_mem_s = a_attr_r[ATTR_MEM];

  // Busy vector from the scoreboard counters; x0 is never busy.
  always_comb begin
    busy_s = 32'd0;
    for (int i = 1; i < 32; i++) begin
      busy_s[i] = (sb_cnt_r[i] != 2'd0);
    end
  end

  // Issue decision for both slots and the input handshake.
  always_comb begin
    a_iss_s = a_valid_r
              && !busy_s[f_ra(a_regs_r)]
              && !busy_s[f_rb(a_regs_r)]
              && !hold && !flush;

    // No forwarding inside a pair: B may not consume A's result.
    b_raw_s = f_writes(a_attr_r, a_regs_r)
              && ((f_ra(b_regs_r) == f_rd(a_regs_r))
                  || (f_rb(b_regs_r) == f_rd(a_regs_r)));

    b_ops_free_s = !busy_s[f_ra(b_regs_r)] && !busy_s[f_rb(b_regs_r)];

    // B waits behind a branch in A and never takes a mem op to pipe1.
    b_iss_s = a_iss_s && b_valid_r && b_ops_free_s && !b_raw_s
              && !a_attr_r[ATTR_BR] && !b_attr_r[ATTR_MEM];

    // Buffer is free for a new pair once every occupied slot leaves.
    slots_clear_s = !a_valid_r || (a_iss_s && (!b_valid_r || b_iss_s));

    in_ready = !hold && !flush && slots_clear_s;
    accept_s = in_valid_a && in_ready;

    // Flush still lets the counters age so no stale busy lingers.
    sb_update_s = flush || !hold;
  end

  // Next scoreboard value per register: pipe1 writer wins over pipe0.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      if (i == 0) begin
        sb_nxt_s[i] = 2'd0;
      end else if (b_iss_s && f_writes(b_attr_r, b_regs_r)
                   && (f_rd(b_regs_r) == 5'(i))) begin
        sb_nxt_s[i] = f_lat(b_attr_r);
      end else if (a_iss_s && f_writes(a_attr_r, a_regs_r)
                   && (f_rd(a_regs_r) == 5'(i))) begin
        sb_nxt_s[i] = f_lat(a_attr_r);
      end else if (sb_cnt_r[i] != 2'd0) begin
        sb_nxt_s[i] = sb_cnt_r[i] - 2'd1;
      end else begin
        sb_nxt_s[i] = 2'd0;
      end
    end
  end

  // Scoreboard counter register.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      for (int i = 0; i < 32; i++) begin
        sb_cnt_r[i] <= 2'd0;
      end
    end else if (sb_update_s) begin
      for (int i = 0; i < 32; i++) begin
        sb_cnt_r[i] <= sb_nxt_s[i];
      end
    end
  end

  // Two-slot instruction buffer: accept, shift B->A, or drain.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      a_valid_r <= 1'b0;
      b_valid_r <= 1'b0;
      a_pc_r    <= 32'd0;
      b_pc_r    <= 32'd0;
      a_inst_r  <= 32'd0;
      b_inst_r  <= 32'd0;
      a_regs_r  <= 15'd0;
      b_regs_r  <= 15'd0;
      a_attr_r  <= 4'd0;
      b_attr_r  <= 4'd0;
    end else if (flush) begin
      a_valid_r <= 1'b0;
      b_valid_r <= 1'b0;
    end else if (hold) begin
      a_valid_r <= a_valid_r;
      b_valid_r <= b_valid_r;
    end else if (accept_s) begin
      a_valid_r <= 1'b1;
      b_valid_r <= in_valid_b;
      a_pc_r    <= in_pc_a;
      b_pc_r    <= in_pc_b;
      a_inst_r  <= in_inst_a;
      b_inst_r  <= in_inst_b;
      a_regs_r  <= in_regs_a;
      b_regs_r  <= in_regs_b;
      a_attr_r  <= in_attr_a;
      b_attr_r  <= in_attr_b;
    end else if (a_iss_s && b_valid_r && !b_iss_s) begin
      // A left alone: B becomes the oldest instruction.
      a_valid_r <= 1'b1;
      b_valid_r <= 1'b0;
      a_pc_r    <= b_pc_r;
      a_inst_r  <= b_inst_r;
      a_regs_r  <= b_regs_r;
      a_attr_r  <= b_attr_r;
    end else if (a_iss_s) begin
      a_valid_r <= 1'b0;
      b_valid_r <= 1'b0;
    end
  end

  // Issue registers towards pipe0 / pipe1 and the dual-issue counter.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      iss0_valid <= 1'b0;
      iss1_valid <= 1'b0;
      iss0_pc    <= 32'd0;
      iss1_pc    <= 32'd0;
      iss0_inst  <= 32'd0;
      iss1_inst  <= 32'd0;
      iss0_regs  <= 15'd0;
      iss1_regs  <= 15'd0;
      dual_cnt   <= 32'd0;
    end else if (flush) begin
      iss0_valid <= 1'b0;
      iss1_valid <= 1'b0;
    end else if (!hold) begin
      iss0_valid <= a_iss_s;
      iss1_valid <= b_iss_s;
      if (a_iss_s) begin
        iss0_pc   <= a_pc_r;
        iss0_inst <= a_inst_r;
        iss0_regs <= a_regs_r;
      end
      if (b_iss_s) begin
        iss1_pc   <= b_pc_r;
        iss1_inst <= b_inst_r;
        iss1_regs <= b_regs_r;
        // b_iss_s implies a_iss_s, so this is exactly a dual-issue cycle.
        dual_cnt  <= dual_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_riscv_issue_ctrl
//
// Table-driven bench for riscv_issue_ctrl (ALU_LAT=0, LOAD_LAT=1). Each table
// row is one clock: inputs to drive, in_ready expected in that cycle, and the
// issue outputs expected after the edge. Expected outputs are queued when the
// row is driven and popped and compared after the edge. A hand-written
// sequence covers reset with a pending slot and a busy register.
// ---------------------------------------------------------------------------
module tb_riscv_issue_ctrl;

  typedef struct {
    logic        hold;
    logic        flush;
    logic        va;
    logic        vb;
    logic [31:0] pc_a;
    logic [31:0] pc_b;
    logic [14:0] regs_a;
    logic [14:0] regs_b;
    logic [3:0]  attr_a;
    logic [3:0]  attr_b;
    logic        e_rdy;
    logic        e_v0;
    logic [31:0] e_pc0;
    logic [14:0] e_regs0;
    logic        e_v1;
    logic [31:0] e_pc1;
    logic [14:0] e_regs1;
    logic [31:0] e_dual;
  } vec_t;

  localparam logic [3:0] ALU = 4'b1000;
  localparam logic [3:0] LD  = 4'b1110;
  localparam logic [3:0] ST  = 4'b0010;
  localparam logic [3:0] BR  = 4'b0001;

  logic        clk;
  logic        srst_n;
  logic        hold;
  logic        flush;
  logic        in_valid_a;
  logic        in_valid_b;
  logic        in_ready;
  logic [31:0] in_pc_a;
  logic [31:0] in_pc_b;
  logic [31:0] in_inst_a;
  logic [31:0] in_inst_b;
  logic [14:0] in_regs_a;
  logic [14:0] in_regs_b;
  logic [3:0]  in_attr_a;
  logic [3:0]  in_attr_b;
  logic        iss0_valid;
  logic        iss1_valid;
  logic [31:0] iss0_pc;
  logic [31:0] iss1_pc;
  logic [31:0] iss0_inst;
  logic [31:0] iss1_inst;
  logic [14:0] iss0_regs;
  logic [14:0] iss1_regs;
  logic [31:0] dual_cnt;

  int n_checks = 0;
  int n_errors = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  riscv_issue_ctrl #(.ALU_LAT(0), .LOAD_LAT(1)) dut (
    .clk(clk), .srst_n(srst_n), .hold(hold), .flush(flush),
    .in_valid_a(in_valid_a), .in_valid_b(in_valid_b), .in_ready(in_ready),
    .in_pc_a(in_pc_a), .in_pc_b(in_pc_b),
    .in_inst_a(in_inst_a), .in_inst_b(in_inst_b),
    .in_regs_a(in_regs_a), .in_regs_b(in_regs_b),
    .in_attr_a(in_attr_a), .in_attr_b(in_attr_b),
    .iss0_valid(iss0_valid), .iss1_valid(iss1_valid),
    .iss0_pc(iss0_pc), .iss1_pc(iss1_pc),
    .iss0_inst(iss0_inst), .iss1_inst(iss1_inst),
    .iss0_regs(iss0_regs), .iss1_regs(iss1_regs),
    .dual_cnt(dual_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] rr(input int ra, input int rb, input int rd);
    return {5'(ra), 5'(rb), 5'(rd)};
  endfunction

  // Instruction code the bench drives for a given PC.
  function automatic logic [31:0] code_of(input logic [31:0] pc);
    return pc ^ 32'h0000_0013;
  endfunction

  function automatic vec_t mk(input logic h, input logic f, input logic va, input logic vb,
                              input logic [31:0] pa, input logic [14:0] ga, input logic [3:0] aa,
                              input logic [31:0] pb, input logic [14:0] gb, input logic [3:0] ab,
                              input logic rdy,
                              input logic v0, input logic [31:0] p0, input logic [14:0] g0,
                              input logic v1, input logic [31:0] p1, input logic [14:0] g1,
                              input logic [31:0] d);
    vec_t t;
    t.hold = h; t.flush = f; t.va = va; t.vb = vb;
    t.pc_a = pa; t.regs_a = ga; t.attr_a = aa;
    t.pc_b = pb; t.regs_b = gb; t.attr_b = ab;
    t.e_rdy = rdy;
    t.e_v0 = v0; t.e_pc0 = p0; t.e_regs0 = g0;
    t.e_v1 = v1; t.e_pc1 = p1; t.e_regs1 = g1;
    t.e_dual = d;
    return t;
  endfunction

  // Cycle with no new decode input.
  function automatic vec_t idle(input logic h, input logic f, input logic rdy,
                                input logic v0, input logic [31:0] p0, input logic [14:0] g0,
                                input logic v1, input logic [31:0] p1, input logic [14:0] g1,
                                input logic [31:0] d);
    return mk(h, f, 1'b0, 1'b0, 32'd0, 15'd0, 4'd0, 32'd0, 15'd0, 4'd0,
              rdy, v0, p0, g0, v1, p1, g1, d);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_out(input int idx, input vec_t e);
    chk($sformatf("r%0d iss0_valid", idx), {31'd0, iss0_valid}, {31'd0, e.e_v0});
    chk($sformatf("r%0d iss1_valid", idx), {31'd0, iss1_valid}, {31'd0, e.e_v1});
    chk($sformatf("r%0d dual_cnt", idx), dual_cnt, e.e_dual);
    if (e.e_v0) begin
      chk($sformatf("r%0d iss0_pc", idx), iss0_pc, e.e_pc0);
      chk($sformatf("r%0d iss0_inst", idx), iss0_inst, code_of(e.e_pc0));
      chk($sformatf("r%0d iss0_regs", idx), {17'd0, iss0_regs}, {17'd0, e.e_regs0});
    end
    if (e.e_v1) begin
      chk($sformatf("r%0d iss1_pc", idx), iss1_pc, e.e_pc1);
      chk($sformatf("r%0d iss1_inst", idx), iss1_inst, code_of(e.e_pc1));
      chk($sformatf("r%0d iss1_regs", idx), {17'd0, iss1_regs}, {17'd0, e.e_regs1});
    end
  endtask

  task automatic drive_idle();
    hold = 1'b0; flush = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    in_pc_a = 32'd0; in_pc_b = 32'd0;
    in_inst_a = 32'd0; in_inst_b = 32'd0;
    in_regs_a = 15'd0; in_regs_b = 15'd0;
    in_attr_a = 4'd0; in_attr_b = 4'd0;
  endtask

  // One table row: drive, check in_ready, queue expectation, compare after edge.
  task automatic step(input int idx, input vec_t t);
    vec_t e;
    @(negedge clk);
    hold = t.hold; flush = t.flush;
    in_valid_a = t.va; in_valid_b = t.vb;
    in_pc_a = t.pc_a; in_pc_b = t.pc_b;
    in_inst_a = code_of(t.pc_a); in_inst_b = code_of(t.pc_b);
    in_regs_a = t.regs_a; in_regs_b = t.regs_b;
    in_attr_a = t.attr_a; in_attr_b = t.attr_b;
    #1;
    chk($sformatf("r%0d in_ready", idx), {31'd0, in_ready}, {31'd0, t.e_rdy});
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    cmp_out(idx, e);
  endtask

  initial begin
    int idx;
    srst_n = 1'b0;
    drive_idle();

    // Independent pair, both issue one cycle after accept.
    tbl.push_back(mk(0,0,1,1, 32'h100, rr(2,3,1), ALU, 32'h104, rr(5,6,4), ALU, 1, 0,0,0, 0,0,0, 0));
    tbl.push_back(idle(0,0,1, 1,32'h100,rr(2,3,1), 1,32'h104,rr(5,6,4), 1));
    // Intra-pair RAW: sub waits and then issues alone on pipe0.
    tbl.push_back(mk(0,0,1,1, 32'h200, rr(2,3,1), ALU, 32'h204, rr(1,2,7), ALU, 1, 0,0,0, 0,0,0, 1));
    tbl.push_back(idle(0,0,0, 1,32'h200,rr(2,3,1), 0,0,0, 1));
    tbl.push_back(idle(0,0,1, 1,32'h204,rr(1,2,7), 0,0,0, 1));
    // Load-use: one bubble behind lw x5.
    tbl.push_back(mk(0,0,1,0, 32'h300, rr(6,0,5), LD, 32'h0, 15'd0, 4'd0, 1, 0,0,0, 0,0,0, 1));
    tbl.push_back(mk(0,0,1,1, 32'h304, rr(5,9,8), ALU, 32'h308, rr(11,12,10), ALU, 1, 1,32'h300,rr(6,0,5), 0,0,0, 1));
    tbl.push_back(idle(0,0,0, 0,0,0, 0,0,0, 1));
    tbl.push_back(idle(0,0,1, 1,32'h304,rr(5,9,8), 1,32'h308,rr(11,12,10), 2));
    // Store in slot B goes to pipe0 a cycle later.
    tbl.push_back(mk(0,0,1,1, 32'h400, rr(14,15,13), ALU, 32'h404, rr(17,16,0), ST, 1, 0,0,0, 0,0,0, 2));
    tbl.push_back(idle(0,0,0, 1,32'h400,rr(14,15,13), 0,0,0, 2));
    tbl.push_back(idle(0,0,1, 1,32'h404,rr(17,16,0), 0,0,0, 2));
    // Branch in slot A defers B.
    tbl.push_back(mk(0,0,1,1, 32'h500, rr(1,2,0), BR, 32'h504, rr(3,4,20), ALU, 1, 0,0,0, 0,0,0, 2));
    tbl.push_back(idle(0,0,0, 1,32'h500,rr(1,2,0), 0,0,0, 2));
    tbl.push_back(idle(0,0,1, 1,32'h504,rr(3,4,20), 0,0,0, 2));
    // Hold for 3 cycles with x23 busy and a consumer pending.
    tbl.push_back(mk(0,0,1,1, 32'h600, rr(1,2,23), LD, 32'h604, rr(3,4,24), ALU, 1, 0,0,0, 0,0,0, 2));
    tbl.push_back(mk(0,0,1,1, 32'h608, rr(23,0,25), ALU, 32'h60C, rr(5,6,26), ALU, 1, 1,32'h600,rr(1,2,23), 1,32'h604,rr(3,4,24), 3));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(idle(1,0,0, 1,32'h600,rr(1,2,23), 1,32'h604,rr(3,4,24), 3));
    end
    tbl.push_back(idle(0,0,0, 0,0,0, 0,0,0, 3));
    tbl.push_back(idle(0,0,1, 1,32'h608,rr(23,0,25), 1,32'h60C,rr(5,6,26), 4));
    // Flush together with hold empties the buffer.
    tbl.push_back(mk(0,0,1,1, 32'h700, rr(1,2,27), ALU, 32'h704, rr(3,4,28), ALU, 1, 0,0,0, 0,0,0, 4));
    tbl.push_back(idle(1,1,0, 0,0,0, 0,0,0, 4));
    tbl.push_back(idle(0,0,1, 0,0,0, 0,0,0, 4));
    // Input presented during flush is dropped.
    tbl.push_back(mk(0,1,1,1, 32'h800, rr(1,2,29), ALU, 32'h804, rr(3,4,30), ALU, 0, 0,0,0, 0,0,0, 4));
    tbl.push_back(idle(0,0,1, 0,0,0, 0,0,0, 4));

    repeat (3) @(posedge clk);
    #1;
    chk("reset iss0_valid", {31'd0, iss0_valid}, 32'd0);
    chk("reset iss1_valid", {31'd0, iss1_valid}, 32'd0);
    chk("reset iss0_pc", iss0_pc, 32'd0);
    chk("reset iss1_pc", iss1_pc, 32'd0);
    chk("reset iss0_inst", iss0_inst, 32'd0);
    chk("reset iss1_inst", iss1_inst, 32'd0);
    chk("reset iss0_regs", {17'd0, iss0_regs}, 32'd0);
    chk("reset iss1_regs", {17'd0, iss1_regs}, 32'd0);
    chk("reset dual_cnt", dual_cnt, 32'd0);
    @(negedge clk);
    srst_n = 1'b1;

    idx = 0;
    foreach (tbl[i]) begin
      step(idx, tbl[i]);
      idx++;
    end

    // Reset while slot B is pending and x5 is busy.
    step(idx, mk(0,0,1,1, 32'h900, rr(1,2,5), LD, 32'h904, rr(5,3,29), ALU, 1, 0,0,0, 0,0,0, 4));
    idx++;
    step(idx, idle(0,0,0, 1,32'h900,rr(1,2,5), 0,0,0, 4));
    idx++;
    @(negedge clk);
    drive_idle();
    srst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid reset iss0_valid", {31'd0, iss0_valid}, 32'd0);
    chk("mid reset iss1_valid", {31'd0, iss1_valid}, 32'd0);
    chk("mid reset iss0_pc", iss0_pc, 32'd0);
    chk("mid reset iss0_regs", {17'd0, iss0_regs}, 32'd0);
    chk("mid reset dual_cnt", dual_cnt, 32'd0);
    @(negedge clk);
    srst_n = 1'b1;
    #1;
    chk("post reset in_ready", {31'd0, in_ready}, 32'd1);
    // Reader of x5 issues without a bubble: counter was cleared.
    step(idx, mk(0,0,1,0, 32'hA00, rr(5,0,30), ALU, 32'h0, 15'd0, 4'd0, 1, 0,0,0, 0,0,0, 0));
    idx++;
    step(idx, idle(0,0,1, 1,32'hA00,rr(5,0,30), 0,0,0, 0));
    idx++;
    step(idx, idle(0,0,1, 0,0,0, 0,0,0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
